// File: rtl/i4001_rom_arb.sv
// Round-robin arbiter sharing one synchronous i4001 ROM among NUM_REQ requesters.
// One grant per cycle; the returned byte is steered to the winner's holding register.
module i4001_rom_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                    sysclk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*12-1:0]   req_addr,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [11:0]             rom_addr,
    input  logic [7:0]              rom_data,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [NUM_REQ*8-1:0]    rsp_data
);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_nxt;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] iss_idx;
    logic             gnt_any;
    logic             inflight;
    logic [11:0]      last_addr;
    logic [11:0]      win_addr;

    // Two passes: indices at/after rr_ptr first, then the wrapped ones below it.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        win_addr = last_addr;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!gnt_any && rst_n && req[j] && (IDX_W'(j) >= rr_ptr)) begin
                gnt_any  = 1'b1;
                gnt_idx  = IDX_W'(j);
                win_addr = req_addr[j*12 +: 12];
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!gnt_any && rst_n && req[j] && (IDX_W'(j) < rr_ptr)) begin
                gnt_any  = 1'b1;
                gnt_idx  = IDX_W'(j);
                win_addr = req_addr[j*12 +: 12];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_REQ; j++) begin
            gnt[j]       = gnt_any && (gnt_idx == IDX_W'(j));
            rsp_valid[j] = inflight && (iss_idx == IDX_W'(j));
        end
    end

    assign rom_addr = win_addr;
    assign rr_nxt   = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            inflight  <= 1'b0;
            iss_idx   <= '0;
            last_addr <= '0;
            rsp_data  <= '0;
        end else begin
            if (gnt_any) begin
                rr_ptr    <= rr_nxt;
                last_addr <= win_addr;
            end
            inflight <= gnt_any;
            iss_idx  <= gnt_idx;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (inflight && (iss_idx == IDX_W'(j)))
                    rsp_data[j*8 +: 8] <= rom_data;
            end
        end
    end

endmodule
